// File: rtl/usonic_pkg.sv
// Shared definitions for the ultrasonic ranging chain: FSM states, default
// widths and the saturating rectifier used on the filtered sample stream.
package usonic_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TOF_W       = 12;
  localparam int DEF_MAX_SAMPLES = 3900;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // |x| of a w-bit sample (sign-extended to DEF_DATA_W); the most-negative
  // code clamps to 2^(w-1)-1 so the result always fits in w-1 bits.
  function automatic logic [DEF_DATA_W-2:0] sat_mag(input logic signed [DEF_DATA_W-1:0] x,
                                                    input int unsigned w);
    logic [DEF_DATA_W-1:0] lim;
    logic [DEF_DATA_W-1:0] mag;
    lim = (DEF_DATA_W'(1) << (w - 32'd1)) - DEF_DATA_W'(1);
    mag = x[DEF_DATA_W-1] ? (DEF_DATA_W'(0) - $unsigned(x)) : $unsigned(x);
    return (DEF_DATA_W-1)'((mag > lim) ? lim : mag);
  endfunction

endpackage

// File: rtl/abs_sat.sv
// Registered saturating rectifier: one pipeline stage on the sample path,
// with the sample strobe delayed alongside it. DATA_W up to DEF_DATA_W.
module abs_sat
  import usonic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              SYS_CLK,
  input  logic              RSTbar,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-2:0] out_mag
);

  logic [DATA_W-2:0] mag_s;
  logic              valid_r;
  logic [DATA_W-2:0] mag_r;

  assign mag_s = (DATA_W-1)'(sat_mag(DEF_DATA_W'($signed(in_data)), DATA_W));

  // magnitude and strobe pipeline register
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      valid_r <= 1'b0;
      mag_r   <= {(DATA_W-1){1'b0}};
    end else begin
      valid_r <= in_valid;
      mag_r   <= mag_s;
    end
  end

  assign out_valid = valid_r;
  assign out_mag   = mag_r;

endmodule

// File: rtl/echo_tof_detector.sv
// Time-of-flight echo detector: first sample of an N_CONFIRM-long run above
// threshold after blanking, or a timeout. Peak tracking built only with ECHO_PEAK_EN.
module echo_tof_detector
  import usonic_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TOF_W       = DEF_TOF_W,
  parameter int N_CONFIRM   = 3,
  parameter int MAX_SAMPLES = DEF_MAX_SAMPLES
) (
  input  logic              SYS_CLK,
  input  logic              RSTbar,
  input  logic              ENA,
  input  logic              BURST_START,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE_DATA,
  input  logic [DATA_W-2:0] THRESH,
  input  logic [TOF_W-1:0]  BLANK,
  output logic [TOF_W-1:0]  TOF,
  output logic [DATA_W-2:0] PEAK,
  output logic              TOF_VALID,
  output logic              TIMEOUT,
  output logic              BUSY
);

  localparam logic [TOF_W-1:0] LAST_IDX   = TOF_W'(MAX_SAMPLES - 1);
  localparam logic [TOF_W-1:0] ONE_IDX    = TOF_W'(1);
  localparam logic [3:0]       RUN_TARGET = 4'(N_CONFIRM);

  logic              s_valid_s;
  logic [DATA_W-2:0] s_mag_s;
  logic              above_s;
  logic              last_s;
  logic              run_done_s;

  state_t            state_r, state_nx_s;
  logic [DATA_W-2:0] thresh_r, thresh_nx_s;
  logic [TOF_W-1:0]  blank_r, blank_nx_s;
  logic [TOF_W-1:0]  idx_r, idx_nx_s;
  logic [TOF_W-1:0]  cand_r, cand_nx_s;
  logic [TOF_W-1:0]  tof_r, tof_nx_s;
  logic [3:0]        run_r, run_nx_s;
  logic              tof_valid_r, tof_valid_nx_s;
  logic              timeout_r, timeout_nx_s;
  logic              busy_r, busy_nx_s;

  // A sample coincident with BURST_START is dropped before the pipeline.
  abs_sat #(.DATA_W(DATA_W)) u_abs_sat (
    .SYS_CLK  (SYS_CLK),
    .RSTbar   (RSTbar),
    .in_valid (SAMPLE_VALID & ~BURST_START),
    .in_data  (SAMPLE_DATA),
    .out_valid(s_valid_s),
    .out_mag  (s_mag_s)
  );

  assign above_s    = (s_mag_s > thresh_r);
  assign last_s     = (idx_r == LAST_IDX);
  assign run_done_s = ((run_r + 4'd1) == RUN_TARGET);

  // next-state and output decode for the burst FSM
  always_comb begin
    state_nx_s     = state_r;
    thresh_nx_s    = thresh_r;
    blank_nx_s     = blank_r;
    idx_nx_s       = idx_r;
    cand_nx_s      = cand_r;
    tof_nx_s       = tof_r;
    run_nx_s       = run_r;
    tof_valid_nx_s = 1'b0;
    timeout_nx_s   = 1'b0;
    busy_nx_s      = busy_r;
    if (!ENA) begin
      state_nx_s = ST_IDLE;
      busy_nx_s  = 1'b0;
    end else if (BURST_START) begin
      thresh_nx_s = THRESH;
      blank_nx_s  = BLANK;
      idx_nx_s    = {TOF_W{1'b0}};
      run_nx_s    = 4'd0;
      busy_nx_s   = 1'b1;
      if (BLANK == {TOF_W{1'b0}}) begin
        state_nx_s = ST_SEARCH;
      end else begin
        state_nx_s = ST_BLANK;
      end
    end else if (s_valid_s && (state_r == ST_BLANK || state_r == ST_SEARCH ||
                               state_r == ST_CONFIRM)) begin
      idx_nx_s = idx_r + ONE_IDX;
      case (state_r)
        ST_BLANK: begin
          if (last_s) begin
            state_nx_s = ST_IDLE; timeout_nx_s = 1'b1; busy_nx_s = 1'b0;
          end else if (idx_r == blank_r - ONE_IDX) begin
            state_nx_s = ST_SEARCH;
          end else begin
            state_nx_s = ST_BLANK;
          end
        end
        ST_SEARCH: begin
          if (above_s) begin
            cand_nx_s = idx_r;
            run_nx_s  = 4'd1;
            if (RUN_TARGET == 4'd1) begin
              state_nx_s = ST_DONE; tof_nx_s = idx_r; tof_valid_nx_s = 1'b1; busy_nx_s = 1'b0;
            end else begin
              state_nx_s = ST_CONFIRM;
            end
          end else if (last_s) begin
            state_nx_s = ST_IDLE; timeout_nx_s = 1'b1; busy_nx_s = 1'b0;
          end else begin
            state_nx_s = ST_SEARCH;
          end
        end
        ST_CONFIRM: begin
          if (above_s) begin
            run_nx_s = run_r + 4'd1;
            if (run_done_s) begin
              state_nx_s = ST_DONE; tof_nx_s = cand_r; tof_valid_nx_s = 1'b1; busy_nx_s = 1'b0;
            end else if (last_s) begin
              state_nx_s = ST_IDLE; timeout_nx_s = 1'b1; busy_nx_s = 1'b0;
            end else begin
              state_nx_s = ST_CONFIRM;
            end
          end else begin
            run_nx_s = 4'd0;
            if (last_s) begin
              state_nx_s = ST_IDLE; timeout_nx_s = 1'b1; busy_nx_s = 1'b0;
            end else begin
              state_nx_s = ST_SEARCH;
            end
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          busy_nx_s  = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_IDLE, ST_BLANK, ST_SEARCH, ST_CONFIRM: state_nx_s = state_r;
        default: begin
          state_nx_s = ST_IDLE;
          busy_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      state_r     <= ST_IDLE;
      thresh_r    <= {(DATA_W-1){1'b0}};
      blank_r     <= {TOF_W{1'b0}};
      idx_r       <= {TOF_W{1'b0}};
      cand_r      <= {TOF_W{1'b0}};
      tof_r       <= {TOF_W{1'b0}};
      run_r       <= 4'd0;
      tof_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      thresh_r    <= thresh_nx_s;
      blank_r     <= blank_nx_s;
      idx_r       <= idx_nx_s;
      cand_r      <= cand_nx_s;
      tof_r       <= tof_nx_s;
      run_r       <= run_nx_s;
      tof_valid_r <= tof_valid_nx_s;
      timeout_r   <= timeout_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

`ifdef ECHO_PEAK_EN
  logic              track_s;
  logic              decide_s;
  logic [DATA_W-2:0] peak_nx_s;
  logic [DATA_W-2:0] peak_acc_r;
  logic [DATA_W-2:0] peak_r;

  assign track_s   = ENA && !BURST_START && s_valid_s &&
                     (state_r == ST_SEARCH || state_r == ST_CONFIRM);
  assign decide_s  = tof_valid_nx_s | timeout_nx_s;
  assign peak_nx_s = (track_s && (s_mag_s > peak_acc_r)) ? s_mag_s : peak_acc_r;

  // running maximum, published only when the burst is decided
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      peak_acc_r <= {(DATA_W-1){1'b0}};
      peak_r     <= {(DATA_W-1){1'b0}};
    end else begin
      if (ENA && BURST_START) begin
        peak_acc_r <= {(DATA_W-1){1'b0}};
      end else begin
        peak_acc_r <= peak_nx_s;
      end
      if (decide_s) begin
        peak_r <= peak_nx_s;
      end else begin
        peak_r <= peak_r;
      end
    end
  end

  assign PEAK = peak_r;
`else
  assign PEAK = {(DATA_W-1){1'b0}};
`endif

  assign TOF       = tof_r;
  assign TOF_VALID = tof_valid_r;
  assign TIMEOUT   = timeout_r;
  assign BUSY      = busy_r;

endmodule
